// File: rtl/csa_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_sum_accumulator
// Purpose  : Streaming block-sum stage behind the 8-bit carry select adder.
//            Accepts one adder result {Cout, S[7:0]} per handshake and sums
//            BLOCK_LEN of them into an ACC_WIDTH-bit total. The total is
//            then presented on a valid/ready port together with a sticky
//            overflow flag.
// Ports    : clk                   - rising-edge clock
//            rst_n                 - asynchronous active-low reset
//            clear                 - synchronous block abort
//            in_valid / in_ready   - operand handshake
//            in_sum, in_cout       - adder S[7:0] and Cout
//            out_valid / out_ready - block total handshake
//            out_acc, out_ovf      - block total and its overflow flag
// Options  : CSA_ACC_SATURATE_EN - if defined, the total saturates at all
//            ones instead of wrapping modulo 2^ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module csa_sum_accumulator #(
    parameter int ACC_WIDTH = 16,   // legal range 10..32
    parameter int BLOCK_LEN = 4     // legal range 1..256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_sum,
    input  logic                 in_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int c_CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_ovf;
    logic [ACC_WIDTH-1:0]   r_out_acc;
    logic                   r_out_ovf;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_handshake;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_ovf_next;

    // ------------------------------------------------------------------
    // Handshake decode. in_ready drops combinationally with clear so an
    // operand presented in the same cycle as an abort is never consumed.
    // ------------------------------------------------------------------
    assign in_ready    = (r_state == ST_ACCUM) && !clear;
    assign out_valid   = (r_state == ST_DONE);
    assign w_accept    = in_valid && (r_state == ST_ACCUM) && !clear;
    assign w_handshake = (r_state == ST_DONE) && out_ready;
    assign w_last      = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Adder: the 9-bit operand is zero-extended so bit ACC_WIDTH of the
    // result is exactly the carry out of the accumulator's MSB.
    // ------------------------------------------------------------------
    assign w_sum   = {1'b0, r_acc} + {{(ACC_WIDTH - 8){1'b0}}, in_cout, in_sum};
    assign w_carry = w_sum[ACC_WIDTH];

`ifdef CSA_ACC_SATURATE_EN
    // Once pinned at all ones, any nonzero operand carries again, so the
    // total stays saturated for the rest of the block.
    assign w_acc_next = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    assign w_ovf_next = r_ovf | w_carry;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic; clear overrides everything, including a
    // simultaneous out_ready in ST_DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
        if (clear) begin
            w_state_next = ST_ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator datapath. The output registers are loaded only when a
    // block completes, so they hold across clear and across backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_acc <= '0;
            r_out_ovf <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            r_ovf <= w_ovf_next;
            if (w_last) begin
                r_out_acc <= w_acc_next;
                r_out_ovf <= w_ovf_next;
            end
        end else if (w_handshake) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign out_acc = r_out_acc;
    assign out_ovf = r_out_ovf;

endmodule
`default_nettype wire

// File: doc/csa_sum_accumulator.md
Name: csa_sum_accumulator

Overview:
- Downstream consumer of the 8-bit carry select adder.
- Accepts one adder result per handshake, as the 9-bit value {Cout, S[7:0]} (0..511), and accumulates BLOCK_LEN results into an ACC_WIDTH-bit running total.
- Presents the completed total on a valid/ready output port, with a sticky overflow flag.
- Turns the combinational adder into a streaming block-sum stage.

Parameters:
- ACC_WIDTH, 16: accumulator and output width. Legal range: 10 ≤ ACC_WIDTH ≤ 32.
- BLOCK_LEN, 4: adder results summed per output block. Legal range: 1 ≤ BLOCK_LEN ≤ 256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous block abort; highest priority after reset.
- in_valid  input  1  adder result present.
- in_ready  output  1  stage can accept a result.
- in_sum  input  8  adder S output.
- in_cout  input  1  adder Cout output.
- out_valid  output  1  completed block total available.
- out_ready  input  1  consumer accepts total.
- out_acc  output  ACC_WIDTH  block total.
- out_ovf  output  1  total wrapped or saturated during this block.

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, cnt=0, ovf=0, state=ACCUM, out_valid=0, out_acc=0, out_ovf=0.
  - in_ready=1 once rst_n=1 and clear=0.
- Addend is {in_cout,in_sum}, zero-extended to ACC_WIDTH+1 bits before the add.
- State ACCUM:
  - in_ready = !clear; out_valid=0.
  - Accept: in_valid && in_ready at a rising edge.
    - acc_next = acc + addend.
    - cnt increments.
    - ovf |= carry out of bit ACC_WIDTH-1.
  - If the accepted result is number BLOCK_LEN (cnt==BLOCK_LEN-1 before the edge), at that same edge:
    - out_acc <= acc_next; out_ovf <= ovf_next.
    - out_valid <= 1; state <= DONE.
  - in_valid while in_ready=0 is ignored; no operand is consumed.
- State DONE:
  - in_ready=0; out_valid=1.
  - out_acc and out_ovf are held stable until accepted.
  - On out_valid && out_ready at an edge: out_valid <= 0, acc <= 0, cnt <= 0, ovf <= 0, state <= ACCUM.
  - First new operand can be accepted on the next edge. Dead cycle between blocks is 1 cycle.
- Latency: last operand accepted at edge N -> out_valid high after edge N (registered, 0 extra cycles).
- BLOCK_LEN=1: every accepted operand produces an output. Throughput is one result per 2 cycles.
- clear=1 at an edge, in any state:
  - acc, cnt, ovf and out_valid cleared; state <= ACCUM.
  - out_acc and out_ovf hold their last values.
  - in_ready is 0 combinationally while clear=1, so a simultaneous in_valid is not consumed.
- clear and out_ready both high in DONE: clear wins. Result is the same as a plain clear.
- Reset mid-block: partial sum and count are discarded. The next accepted operand starts a fresh block.
- Wrap: without saturation the total is modulo 2^ACC_WIDTH.

Optional Feature:
- Macro: CSA_ACC_SATURATE_EN
- Defined: when the add would exceed 2^ACC_WIDTH-1, acc is set to all ones and ovf is set.
  - acc stays all ones for the rest of the block.
- Undefined: modulo wrap; ovf still flags any carry out.
- Handshake timing is identical in both builds.

Test Plan:
- Basic block (defaults): four operands {0,0x02}, {1,0x00}, {0,0xFF}, {1,0xFE}, in_valid=1 continuously, out_ready=1.
  - in_ready high for 4 cycles, then low 1 cycle.
  - out_valid 1 cycle with out_acc=0x03FF, out_ovf=0.
- Backpressure: complete a block, hold out_ready=0 for 5 cycles with in_valid=1 and in_sum changing.
  - in_ready=0 throughout; out_acc stable at the block total.
  - After out_ready=1, the next block starts from 0.
- Overflow (ACC_WIDTH=10, BLOCK_LEN=4): four operands {1,0xFF}.
  - Without macro: out_acc=0x3FC, out_ovf=1.
  - With CSA_ACC_SATURATE_EN: out_acc=0x3FF, out_ovf=1.
- Reset mid-block: accept 2 operands of {0,0x10}, pulse rst_n low between edges.
  - All outputs 0 immediately, asynchronously.
  - Then four operands {0,0x01} -> out_acc=0x0004.
- Clear: in ACCUM after 3 operands, clear=1 with in_valid=1.
  - in_ready=0 in that cycle and the operand is dropped.
  - Next block of four {0,0x01} -> out_acc=0x0004.
  - clear in DONE drops out_valid without a handshake.
- BLOCK_LEN=1 streaming: in_valid=1 with values 3, 5, 7 and out_ready=1.
  - Outputs 3, 5, 7 on alternate cycles; in_ready toggles 1,0,1,0.
